// File: rtl/sevenseg_pkg.sv
// Shared constants, types and helpers for the eight-digit seven-segment scanner.
// Brightness dimming is built only when SEVSEG_DIMMING_EN is defined.
package sevenseg_pkg;

    localparam int NUM_DIGITS   = 8;
    localparam int GHOST_CYCLES = 2;
    localparam int SEL_W        = 3;
    localparam int CODE_W       = 5;

    typedef enum logic [CODE_W-1:0] {
        CODE_A     = 5'd16,
        CODE_B     = 5'd17,
        CODE_C     = 5'd18,
        CODE_D     = 5'd19,
        CODE_E     = 5'd20,
        CODE_F     = 5'd21,
        CODE_G     = 5'd22,
        CODE_BLANK = 5'd23
    } seg_code_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs, entry i shows hex digit i
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [NUM_DIGITS-1:0][CODE_W-1:0] code;
        logic [NUM_DIGITS-1:0]             dp;
    } frame_t;

    function automatic frame_t blank_frame();
        frame_t f;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            f.code[i] = CODE_BLANK;
        end
        f.dp = '0;
        return f;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_mask(
        input logic [SEL_W-1:0] sel
    );
        logic [NUM_DIGITS-1:0] one_hot;
        one_hot      = '0;
        one_hot[sel] = 1'b1;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational display-code to active-low segment decoder.
// Codes 0-15 hex glyphs, 16-22 single segment a-g, 23-31 blank.
module sevenseg_decoder
    import sevenseg_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [6:0]        seg
);

    // Select glyph, single lit segment, or blank
    always_comb begin
        seg = SEG_BLANK;
        if (code < 5'd16) begin
            seg = HEX_GLYPH[code[3:0]];
        end else if (code < CODE_BLANK) begin
            seg = ~(7'd1 << (code - CODE_A));
        end
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed eight-digit seven-segment scanner with tear-free frame updates.
// Define SEVSEG_DIMMING_EN to gate the anodes with a 4-bit brightness PWM.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int SIMULATE    = 0,
    parameter int REFRESH_DIV = (SIMULATE != 0) ? 4 : 99_999
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_DIGITS*CODE_W-1:0] digit_code,
    input  logic [NUM_DIGITS-1:0]        dp,
    input  logic                         update,
    input  logic [3:0]                   brightness,
    output logic [NUM_DIGITS-1:0]        an,
    output logic [6:0]                   seg,
    output logic                         dp_n,
    output logic [SEL_W-1:0]             digit_sel
);

    localparam int CW = (REFRESH_DIV < 4) ? 2 : $clog2(REFRESH_DIV + 1);
    localparam logic [CW-1:0] DIV_MAX   = CW'(REFRESH_DIV);
    localparam logic [CW-1:0] GHOST_MIN = CW'(GHOST_CYCLES);
    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_DIGITS - 1);

    logic [CW-1:0]    cnt_q;
    logic [SEL_W-1:0] slot_q;
    frame_t           pending_q;
    frame_t           active_q;
    frame_t           strobe_frame;
    logic             slot_end;
    logic             frame_end;
    logic             ghost_done;
    logic             pwm_on;
    logic             lit;
    logic [6:0]       seg_next;

    assign strobe_frame.code = digit_code;
    assign strobe_frame.dp   = dp;

    assign slot_end   = (cnt_q == DIV_MAX);
    assign frame_end  = slot_end && (slot_q == LAST_SLOT);
    assign ghost_done = (cnt_q >= GHOST_MIN);
    assign lit        = ghost_done && pwm_on;

`ifdef SEVSEG_DIMMING_EN
    logic [3:0] pwm_q;

    // Free-running PWM phase for brightness gating
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
        end
    end

    assign pwm_on = (pwm_q <= brightness);
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness;
    assign pwm_on            = 1'b1;
`endif

    // Refresh counter and scanned slot index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            slot_q <= '0;
        end else if (slot_end) begin
            cnt_q  <= '0;
            slot_q <= slot_q + 1'b1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Latest strobed data waits here until the frame ends
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= blank_frame();
        end else if (update) begin
            pending_q <= strobe_frame;
        end
    end

    // Swap in new data only between frames; a strobe on that edge wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= blank_frame();
        end else if (frame_end) begin
            active_q <= update ? strobe_frame : pending_q;
        end
    end

    sevenseg_decoder u_decoder (
        .code (active_q.code[slot_q]),
        .seg  (seg_next)
    );

    // Register pins together so index, anode and segments move in step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an        <= '1;
            seg       <= SEG_BLANK;
            dp_n      <= 1'b1;
            digit_sel <= '0;
        end else begin
            an        <= lit ? anode_mask(slot_q) : '1;
            seg       <= seg_next;
            dp_n      <= ~(lit && active_q.dp[slot_q]);
            digit_sel <= slot_q;
        end
    end

endmodule
